// File: rtl/bank_read_collector_pkg.sv
// rtl/bank_read_collector_pkg.sv - shared constants and types for the banked read-return path
package bank_read_collector_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int BANK_SEL_W = 2;

    // Hamming parity count, shared with the encoder and the write demultiplexer
    function automatic int parity_bits(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

    function automatic int encoded_word(input int data_width);
        return data_width + parity_bits(data_width);
    endfunction

    // Bank select occupies the two MSBs of the read address
    function automatic int bank_sel_lsb(input int addr_width);
        return addr_width - BANK_SEL_W;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [BANK_SEL_W-1:0] sel;
    } rd_tag_t;

endpackage

// File: rtl/bank_rd_fifo.sv
// rtl/bank_rd_fifo.sv - small synchronous FIFO with registered head and occupancy count
module bank_rd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (i_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/bank_read_collector.sv
// rtl/bank_read_collector.sv - issues banked reads and returns encoded words in request order
module bank_read_collector
    import bank_read_collector_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_BITS  = parity_bits(DATA_WIDTH),
    parameter int ENCODED_WORD = DATA_WIDTH + PARITY_BITS,
    parameter int ADDR_WIDTH   = 4,
    parameter int BANK_LATENCY = 1,
    parameter int FIFO_DEPTH   = BANK_LATENCY + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rd_en,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    o_busy,
    output logic [NUM_BANKS-1:0]    o_bank_rd_en,
    output logic [ADDR_WIDTH-3:0]   o_bank_addr,
    input  logic [ENCODED_WORD+1:1] i_bank0_data,
    input  logic [ENCODED_WORD+1:1] i_bank1_data,
    input  logic [ENCODED_WORD+1:1] i_bank2_data,
    input  logic [ENCODED_WORD+1:1] i_bank3_data,
    output logic [ENCODED_WORD+1:1] o_data,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam int SEL_LSB = bank_sel_lsb(ADDR_WIDTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W  = ENCODED_WORD + 1;

    rd_tag_t tag_q [BANK_LATENCY];
    rd_tag_t tag_d [BANK_LATENCY];

    logic [BANK_SEL_W-1:0] req_sel;
    logic [WORD_W-1:0]     bank_data [NUM_BANKS];
    logic [WORD_W-1:0]     push_data;
    logic [WORD_W-1:0]     fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      inflight;
    logic                  accept;
    logic                  push;
    logic                  pop;

    assign bank_data[0] = i_bank0_data;
    assign bank_data[1] = i_bank1_data;
    assign bank_data[2] = i_bank2_data;
    assign bank_data[3] = i_bank3_data;
    assign req_sel      = i_addr[SEL_LSB +: BANK_SEL_W];

    // A pop this cycle frees a slot in time for a new accept, which is what
    // sustains one read per cycle at the minimum FIFO depth.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BANK_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_q[i].valid);
        end
        pop    = o_valid && i_ready;
        o_busy = (int'(inflight) + int'(fifo_count) - int'(pop)) >= FIFO_DEPTH;
        accept = i_rd_en && !o_busy;

        o_bank_rd_en = '0;
        o_bank_addr  = '0;
        if (accept) begin
            o_bank_rd_en = NUM_BANKS'(1) << req_sel;
            o_bank_addr  = i_addr[SEL_LSB-1:0];
        end
    end

    always_comb begin
        tag_d[0].valid = accept;
        tag_d[0].sel   = req_sel;
        for (int i = 1; i < BANK_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BANK_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    // The final tag stage lines up with the bank's data-valid cycle
    assign push      = tag_q[BANK_LATENCY-1].valid;
    assign push_data = bank_data[tag_q[BANK_LATENCY-1].sel];

    bank_rd_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (push_data),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_count     (fifo_count)
    );

    assign o_data  = fifo_head;
    assign o_valid = (fifo_count != '0);

endmodule

// File: tb/tb_bank_read_collector.sv
// tb/tb_bank_read_collector.sv - directed self-checking bench for bank_read_collector
module tb_bank_read_collector;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [3:0]  addr;
    logic        busy;
    logic [3:0]  bank_rd_en;
    logic [1:0]  bank_addr;
    logic [13:1] bank0_data, bank1_data, bank2_data, bank3_data;
    logic [13:1] data;
    logic        valid;
    logic        ready;

    int n_checks = 0;
    int n_fails  = 0;

    bank_read_collector dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rd_en      (rd_en),
        .i_addr       (addr),
        .o_busy       (busy),
        .o_bank_rd_en (bank_rd_en),
        .o_bank_addr  (bank_addr),
        .i_bank0_data (bank0_data),
        .i_bank1_data (bank1_data),
        .i_bank2_data (bank2_data),
        .i_bank3_data (bank3_data),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [13:1] words [4];

    initial begin
        rst = 1'b1; rd_en = 1'b0; addr = '0; ready = 1'b0;
        bank0_data = 13'h0A1; bank1_data = 13'h0B2;
        bank2_data = 13'h1A5; bank3_data = 13'h1C3;
        tick(); tick();
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(bank_rd_en), 32'd0);
        check_eq("rst_bank_addr", 32'(bank_addr), 32'd0);
        rst = 1'b0;

        // single read to bank 2
        tick();
        rd_en = 1'b1; addr = 4'b1001; ready = 1'b1;
        #1;
        check_eq("single_rd_en", 32'(bank_rd_en), 32'h4);
        check_eq("single_bank_addr", 32'(bank_addr), 32'h1);
        check_eq("single_busy", 32'(busy), 32'd0);
        tick();
        rd_en = 1'b0; #1;
        check_eq("single_idle_rd_en", 32'(bank_rd_en), 32'h0);
        check_eq("single_valid_early", 32'(valid), 32'd0);
        tick();
        check_eq("single_valid", 32'(valid), 32'd1);
        check_eq("single_data", 32'(data), 32'h1A5);
        tick();
        check_eq("single_drained", 32'(valid), 32'd0);

        // back-to-back to banks 0..3 with ready high
        words[0] = bank0_data; words[1] = bank1_data;
        words[2] = bank2_data; words[3] = bank3_data;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                rd_en = 1'b1; addr = 4'(k << 2);
            end else begin
                rd_en = 1'b0;
            end
            #1;
            if (k < 4) begin
                check_eq($sformatf("b2b_busy%0d", k), 32'(busy), 32'd0);
                check_eq($sformatf("b2b_rd_en%0d", k), 32'(bank_rd_en), 32'(4'b0001 << k));
            end
            if (k >= 2) begin
                check_eq($sformatf("b2b_valid%0d", k), 32'(valid), 32'd1);
                check_eq($sformatf("b2b_data%0d", k), 32'(data), 32'(words[k-2]));
            end
            tick();
        end
        check_eq("b2b_drained", 32'(valid), 32'd0);

        // back-pressure: two accepts fill the credits
        ready = 1'b0; rd_en = 1'b1; addr = 4'b0100; #1;
        check_eq("bp_busy0", 32'(busy), 32'd0);
        tick();
        addr = 4'b1000; #1;
        check_eq("bp_busy1", 32'(busy), 32'd0);
        check_eq("bp_rd_en1", 32'(bank_rd_en), 32'h4);
        tick();
        addr = 4'b1100; #1;
        check_eq("bp_busy2", 32'(busy), 32'd1);
        check_eq("bp_rd_en_blocked", 32'(bank_rd_en), 32'h0);
        check_eq("bp_valid2", 32'(valid), 32'd1);
        check_eq("bp_data2", 32'(data), 32'h0B2);
        tick(); tick();
        check_eq("bp_busy_hold", 32'(busy), 32'd1);
        check_eq("bp_data_hold", 32'(data), 32'h0B2);
        rd_en = 1'b0; ready = 1'b1; #1;
        check_eq("bp_pop1_data", 32'(data), 32'h0B2);
        tick();
        check_eq("bp_busy_after_pop", 32'(busy), 32'd0);
        check_eq("bp_pop2_valid", 32'(valid), 32'd1);
        check_eq("bp_pop2_data", 32'(data), 32'h1A5);
        tick();
        check_eq("bp_drained", 32'(valid), 32'd0);

        // simultaneous push and pop with one word held
        bank0_data = 13'h055; bank1_data = 13'h0AA;
        ready = 1'b0; rd_en = 1'b1; addr = 4'b0000;
        tick();
        rd_en = 1'b0;
        tick();
        check_eq("pp_valid", 32'(valid), 32'd1);
        rd_en = 1'b1; addr = 4'b0111;
        tick();
        rd_en = 1'b0; ready = 1'b1; #1;
        check_eq("pp_head_first", 32'(data), 32'h055);
        tick();
        check_eq("pp_count_kept", 32'(valid), 32'd1);
        check_eq("pp_head_second", 32'(data), 32'h0AA);
        tick();
        check_eq("pp_drained", 32'(valid), 32'd0);

        // reset one cycle after accept discards the in-flight read
        bank2_data = 13'h123;
        rd_en = 1'b1; addr = 4'b1000;
        tick();
        rd_en = 1'b0; rst = 1'b1; bank2_data = 13'h0FF; #1;
        check_eq("rst_mid_valid", 32'(valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("rst_mid_valid%0d", k), 32'(valid), 32'd0);
            check_eq($sformatf("rst_mid_data%0d", k), 32'(data), 32'd0);
        end

        // stale data on the other banks while bank 3 is read
        bank0_data = 13'h1FF; bank1_data = 13'h0F0; bank2_data = 13'h00F;
        bank3_data = 13'h1E7;
        rd_en = 1'b1; addr = 4'b1110; #1;
        check_eq("stale_rd_en", 32'(bank_rd_en), 32'h8);
        check_eq("stale_bank_addr", 32'(bank_addr), 32'h2);
        tick();
        rd_en = 1'b0; bank0_data = 13'h111; bank1_data = 13'h122; bank2_data = 13'h133;
        tick();
        check_eq("stale_valid", 32'(valid), 32'd1);
        check_eq("stale_data", 32'(data), 32'h1E7);
        tick();
        check_eq("stale_drained", 32'(valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
